rom_line_ctrl: RTL and testbench

- Instruction-memory controller directly upstream of the rv32 core's instruction-fetch port.
- Serves the core's line-fill requests (32-bit byte address plus valid_req) by reading four consecutive 32-bit words from a synchronous single-port instruction ROM.
- Assembles the four words into a 128-bit line and returns it with a one-cycle ready pulse.
- Supports request abort (core drops valid_req after a jump) and out-of-range addresses.

---
 rtl/rom_line_ctrl.sv | 144 ++++++++++++++
 tb/tb_rom_line_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_line_ctrl.sv
// Line-fill controller between the rv32 fetch port and a synchronous instruction ROM.
// Reads four consecutive words per request and returns them as one 128-bit line.
module rom_line_ctrl #(
    parameter int          ROM_AW    = 12,
    parameter int          EXTRA_LAT = 0,
    parameter logic [31:0] OOR_WORD  = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       core_addr_i,
    input  logic              core_valid_req_i,
    output logic              rom_ready_o,
    output logic [127:0]      rom_data_o,
    output logic              mem_rd_en_o,
    output logic [ROM_AW-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              busy_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [3:0] WAIT_LAST =
        (EXTRA_LAT == 0) ? 4'd0 : 4'(EXTRA_LAT - 1);

    logic [2:0]   state_q, state_d;
    logic [27:0]  line_q, line_d;
    logic [1:0]   iss_q, iss_d;
    logic [1:0]   cap_q, cap_d;
    logic         cap_vld_q, cap_vld_d;
    logic [3:0]   wait_q, wait_d;
    logic [127:0] data_q, data_d;

    logic [29:0]  iss_wa;
    logic [29:0]  cap_wa;
    logic         iss_oor;
    logic         cap_oor;
    logic         in_fill;
    logic         abort;
    logic         unused_addr;

    // Word address of a slot is the line index followed by the slot number.
    assign iss_wa  = {line_q, iss_q};
    assign cap_wa  = {line_q, cap_q};
    assign iss_oor = |iss_wa[29:ROM_AW];
    assign cap_oor = |cap_wa[29:ROM_AW];

    assign in_fill = (state_q == S_READ) || (state_q == S_DRAIN) ||
                     (state_q == S_WAIT);
    assign abort   = in_fill && !core_valid_req_i;

    assign mem_rd_en_o = (state_q == S_READ) && core_valid_req_i && !iss_oor;
    assign mem_addr_o  = mem_rd_en_o ? iss_wa[ROM_AW-1:0] : '0;
    assign rom_ready_o = (state_q == S_RESP);
    assign busy_o      = (state_q != S_IDLE);
    assign rom_data_o  = data_q;
    assign unused_addr = ^core_addr_i[3:0];

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        iss_d     = iss_q;
        cap_d     = cap_q;
        cap_vld_d = 1'b0;
        wait_d    = wait_q;
        data_d    = data_q;

        // Out-of-range slots take the substitute word on the same beat.
        if (cap_vld_q && !abort) begin
            data_d[32*cap_q +: 32] = cap_oor ? OOR_WORD : mem_rdata_i;
            cap_d = cap_q + 2'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (core_valid_req_i) begin
                    line_d  = core_addr_i[31:4];
                    iss_d   = 2'd0;
                    cap_d   = 2'd0;
                    wait_d  = 4'd0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    cap_vld_d = 1'b1;
                    iss_d     = iss_q + 2'd1;
                    if (iss_q == 2'd3) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) state_d = S_IDLE;
                else if (EXTRA_LAT == 0) state_d = S_RESP;
                else state_d = S_WAIT;
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + 4'd1;
                    if (wait_q == WAIT_LAST) state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            iss_d  = 2'd0;
            cap_d  = 2'd0;
            wait_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            line_q    <= '0;
            iss_q     <= '0;
            cap_q     <= '0;
            cap_vld_q <= 1'b0;
            wait_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            iss_q     <= iss_d;
            cap_q     <= cap_d;
            cap_vld_q <= cap_vld_d;
            wait_q    <= wait_d;
            data_q    <= data_d;
        end
    end

endmodule

// File: tb/tb_rom_line_ctrl.sv
// Directed bench for rom_line_ctrl: three instances cover default,
// extra-latency and small-ROM (out-of-range) configurations.
module tb_rom_line_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] addr;
    logic        v0, v1, v2;

    logic         rdy0, rdy1, rdy2;
    logic [127:0] d0, d1, d2;
    logic         en0, en1, en2;
    logic [11:0]  ma0, ma1;
    logic [3:0]   ma2;
    logic [31:0]  rd0, rd1, rd2;
    logic         b0, b1, b2;

    int checks = 0;
    int errors = 0;
    int pulses;

    localparam logic [127:0] L10 =
        128'h77777777_66666666_55555555_44444444;
    localparam logic [127:0] L20 =
        128'hBBBBBBBB_AAAAAAAA_99999999_88888888;
    localparam logic [127:0] L30 =
        128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;
    localparam logic [127:0] LOOR =
        128'h00000013_00000013_00000013_00000013;

    rom_line_ctrl #(.ROM_AW(12), .EXTRA_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .core_addr_i(addr),
        .core_valid_req_i(v0), .rom_ready_o(rdy0),
        .rom_data_o(d0), .mem_rd_en_o(en0), .mem_addr_o(ma0),
        .mem_rdata_i(rd0), .busy_o(b0)
    );

    rom_line_ctrl #(.ROM_AW(12), .EXTRA_LAT(3)) dut1 (
        .clk(clk), .rst(rst), .core_addr_i(addr),
        .core_valid_req_i(v1), .rom_ready_o(rdy1),
        .rom_data_o(d1), .mem_rd_en_o(en1), .mem_addr_o(ma1),
        .mem_rdata_i(rd1), .busy_o(b1)
    );

    rom_line_ctrl #(.ROM_AW(4), .EXTRA_LAT(0)) dut2 (
        .clk(clk), .rst(rst), .core_addr_i(addr),
        .core_valid_req_i(v2), .rom_ready_o(rdy2),
        .rom_data_o(d2), .mem_rd_en_o(en2), .mem_addr_o(ma2),
        .mem_rdata_i(rd2), .busy_o(b2)
    );

    // ROM[k] = k * 0x11111111
    always @(posedge clk) begin
        if (en0) rd0 <= 32'(ma0) * 32'h1111_1111;
        if (en1) rd1 <= 32'(ma1) * 32'h1111_1111;
        if (en2) rd2 <= 32'(ma2) * 32'h1111_1111;
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        addr = 32'h0;
        v0   = 1'b0;
        v1   = 1'b0;
        v2   = 1'b0;
        repeat (3) nxt();
        #1;
        chk("rst_ready", 128'(rdy0), 128'(0));
        chk("rst_data", d0, 128'h0);
        chk("rst_en", 128'(en0), 128'(0));
        chk("rst_addr", 128'(ma0), 128'(0));
        chk("rst_busy", 128'({b0, b1, b2}), 128'(0));
        rst = 1'b0;

        // Basic fill of line 0x20
        nxt();
        addr = 32'h20;
        v0   = 1'b1;
        #1;
        chk("t1_idle_busy", 128'(b0), 128'(0));
        for (int c = 1; c <= 7; c++) begin
            nxt();
            if (c == 6) v0 = 1'b0;
            #1;
            chk("t1_en", 128'(en0), 128'(c <= 4));
            chk("t1_addr", 128'(ma0), 128'((c <= 4) ? 7 + c : 0));
            chk("t1_ready", 128'(rdy0), 128'(c == 6));
            chk("t1_busy", 128'(b0), 128'(c <= 6));
            if (c >= 6) chk("t1_data", d0, L20);
        end

        // Abort at T+3, new request at T+5
        nxt();
        addr = 32'h20;
        v0   = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            nxt();
            if (c == 3) v0 = 1'b0;
            if (c == 5) begin
                addr = 32'h30;
                v0   = 1'b1;
            end
            if (c == 11) v0 = 1'b0;
            #1;
            if (c <= 2) chk("ab_en", 128'(en0), 128'(1));
            if (c == 3) begin
                chk("ab_en_gate", 128'(en0), 128'(0));
                chk("ab_addr_gate", 128'(ma0), 128'(0));
                chk("ab_busy3", 128'(b0), 128'(1));
            end
            if (c == 4 || c == 5 || c == 12)
                chk("ab_idle", 128'(b0), 128'(0));
            chk("ab_ready", 128'(rdy0), 128'(c == 11));
            if (c == 11) chk("ab_data", d0, L30);
        end

        // Reset mid-fill, request held across reset
        nxt();
        addr = 32'h10;
        v0   = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            nxt();
            if (c == 2) rst = 1'b1;
            if (c == 3) rst = 1'b0;
            if (c == 9) v0 = 1'b0;
            #1;
            if (c == 3) begin
                chk("rs_data", d0, 128'h0);
                chk("rs_en", 128'(en0), 128'(0));
                chk("rs_addr", 128'(ma0), 128'(0));
                chk("rs_busy", 128'(b0), 128'(0));
            end
            chk("rs_ready", 128'(rdy0), 128'(c == 9));
            if (c == 9) chk("rs_data2", d0, L10);
        end

        // Extra latency 3, unaligned address
        nxt();
        addr = 32'h2C;
        v1   = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            nxt();
            if (c == 9) v1 = 1'b0;
            #1;
            chk("xl_busy", 128'(b1), 128'(c <= 9));
            chk("xl_ready", 128'(rdy1), 128'(c == 9));
            if (c == 9) chk("xl_data", d1, L20);
        end

        // Small ROM: line beyond the end
        nxt();
        addr   = 32'h40;
        v2     = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 7; c++) begin
            nxt();
            if (c == 6) v2 = 1'b0;
            #1;
            if (en2) pulses++;
            chk("oor_ready", 128'(rdy2), 128'(c == 6));
            if (c == 6) chk("oor_data", d2, LOOR);
        end
        chk("oor_pulses", 128'(pulses), 128'(0));

        // Small ROM: last in-range line
        nxt();
        addr   = 32'h38;
        v2     = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 7; c++) begin
            nxt();
            if (c == 6) v2 = 1'b0;
            #1;
            if (en2) pulses++;
            if (c == 4) chk("top_addr", 128'(ma2), 128'(15));
            chk("top_ready", 128'(rdy2), 128'(c == 6));
            if (c == 6) chk("top_data", d2, L30);
        end
        chk("top_pulses", 128'(pulses), 128'(4));

        // Back-to-back with request held through RESP
        nxt();
        addr = 32'h20;
        v0   = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            nxt();
            if (c == 6) addr = 32'h30;
            if (c == 13) v0 = 1'b0;
            #1;
            chk("bb_ready", 128'(rdy0), 128'(c == 6 || c == 13));
            if (c >= 6 && c <= 9) chk("bb_data1", d0, L20);
            if (c == 13) chk("bb_data2", d0, L30);
            if (c == 7) chk("bb_busy7", 128'(b0), 128'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
